sync_bit_arbiter: RTL and testbench
===================================

// Module: sync_bit_arbiter
// PURPOSE
//  Source-domain controller sharing one toggle-handshake crossing (forward SyncBit plus return SyncBit) between N requesters.
//  Round-robin picks a requester, flips the forward toggle, waits for the echoed toggle, then completes the requester.
//  One event is in flight at a time. Sits on the sending side of a clock-domain crossing.
// PARAMETERS
//  NREQ     4    number of requesters, 2..16
//  INIT     1'b0 reset value of the toggle; must equal the SyncBit init of both crossings
//  MIN_GAP  2    idle cycles forced after each completion, 0..15
//  TIMEOUT  255  WAIT cycles before abort; used only when SYNC_ARB_TIMEOUT_EN is defined
// PORTS
//  CLK       in   1           sole clock; also drives sCLK of the forward SyncBit
//  RST       in   1           synchronous, active-high reset
//  req       in   NREQ        level request; held until done
//  sync_en   out  1           to forward SyncBit sEN; one-cycle pulse per event
//  sync_d    out  1           to forward SyncBit sD_IN; current toggle level
//  ack_sync  in   1           return SyncBit dD_OUT; already in the CLK domain
//  done      out  NREQ        one-hot, one-cycle completion pulse
//  err       out  1           one-cycle pulse, coincident with done, on timeout abort
//  busy      out  1           high in every state other than IDLE
//  cur_idx   out  clog2(NREQ) index of the requester being served; valid while busy
// BEHAVIOUR
//  Reset (sync, RST=1 at posedge CLK):
//   - state=IDLE, sync_d=INIT, sync_en=0, done=0, err=0, busy=0, cur_idx=0.
//   - Round-robin pointer=0; gap counter=0.
//   - Mid-operation reset abandons the event; no done is issued.
//   - The far side must be reset on the same RST so both toggles return to INIT.
//  States: IDLE -> SEND -> WAIT -> GAP -> IDLE. All outputs are registered.
//  IDLE:
//   - If req != 0, select the first set bit at or after ptr, wrapping at NREQ-1 -> 0.
//   - Latch cur_idx, go to SEND. With no request, stay in IDLE.
//  SEND:
//   - For exactly one cycle: sync_d <= ~sync_d, sync_en=1.
//   - Go to WAIT. Latency: req rises at cycle 0 -> sync_en high at cycle 2.
//  WAIT:
//   - When ack_sync == sync_d: done[cur_idx]=1 for one cycle, ptr <= cur_idx+1 (mod NREQ), go to GAP.
//   - Requests arriving in WAIT are only sampled after returning to IDLE.
//  GAP:
//   - Stay MIN_GAP cycles, then IDLE. With MIN_GAP=0, go straight to IDLE.
//   - busy stays high in GAP.
//  Fairness:
//   - The last-served requester has lowest priority next round.
//   - A single requester holding req high is served back-to-back, separated only by GAP.
//  Boundaries:
//   - req dropped before done: the event still completes and done still pulses; the requester ignores it.
//   - ptr wrap-around from NREQ-1 to 0 is required.
//   - Non-power-of-2 NREQ: indices >= NREQ are never selected.
//   - ack_sync != sync_d while in IDLE or GAP is a protocol error; ignore it (it only matters in WAIT).
// CONFIGURATION
//  SYNC_ARB_TIMEOUT_EN defined:
//   - A 16-bit counter clears on entry to WAIT and increments every WAIT cycle.
//   - At count==TIMEOUT with no ack: done[cur_idx]=1, err=1, go to DRAIN.
//   - DRAIN (busy=1) waits for ack_sync == sync_d, then goes to GAP. This prevents toggle desync.
//   - If the ack and the timeout hit in the same cycle, the ack wins (err=0).
//  SYNC_ARB_TIMEOUT_EN not defined:
//   - No counter and no DRAIN state; err is tied to 0; WAIT waits forever.
// TESTING (bench models the far side as a 3..8-cycle delayed echo of sync_d onto ack_sync)
//  1. Reset with INIT=0, then req=4'b0001, echo delay 5:
//     -> sync_en pulses at cycle 2, sync_d=1, done=4'b0001 at cycle 8 (one cycle after ack_sync matches), busy low 2 cycles later.
//  2. req=4'b1111 held, MIN_GAP=2:
//     -> done order 0001,0010,0100,1000,0001; sync_d alternates 1,0,1,0,1.
//  3. Serve 3, then req=4'b1001:
//     -> index 0 served before 3 (wrap-around); cur_idx=0 then 3.
//  4. RST=1 for one cycle during WAIT:
//     -> next cycle state IDLE, sync_d=INIT, busy=0, no done pulse; the next request handshakes normally.
//  5. Timeout build, TIMEOUT=20, echo disabled:
//     -> done and err pulse at WAIT cycle 20.
//     -> Echo then enabled: busy drops only after ack_sync matches plus MIN_GAP.
//  6. Timeout build, ack arrives exactly at count 20:
//     -> done=1, err=0.

Source files
------------

// File: rtl/sync_bit_arbiter.sv
// sync_bit_arbiter: round-robin owner of one toggle-handshake crossing shared by NREQ requesters.
// Define SYNC_ARB_TIMEOUT_EN to add WAIT timeout abort with a DRAIN state that re-aligns the toggles.
module sync_bit_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter logic        INIT    = 1'b0,
    parameter int unsigned MIN_GAP = 2,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NREQ-1:0]          req,
    output logic                     sync_en,
    output logic                     sync_d,
    input  logic                     ack_sync,
    output logic [NREQ-1:0]          done,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(NREQ)-1:0]  cur_idx
);

    localparam int unsigned IDXW = $clog2(NREQ);
    localparam int unsigned GAPW = 4;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SEND  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] GAP   = 3'd3;
`ifdef SYNC_ARB_TIMEOUT_EN
    localparam logic [2:0] DRAIN = 3'd4;
`endif
    localparam logic [2:0] AFTER_ACK = (MIN_GAP == 0) ? IDLE : GAP;

    logic [2:0]      state, stateNext;
    logic [IDXW-1:0] ptr, ptrNext;
    logic [GAPW-1:0] gapCnt, gapCntNext;
    logic [IDXW-1:0] pickIdx, curIdxNext, idxWrap;
    logic            syncDNext, syncEnNext, errNext, busyNext;
    logic [NREQ-1:0] doneNext;
    logic            ackMatch;
    int unsigned     offset;

`ifdef SYNC_ARB_TIMEOUT_EN
    logic [15:0]     toCnt, toCntNext;
`else
    logic            unusedTimeout;
    assign unusedTimeout = ^32'(TIMEOUT);
`endif

    assign ackMatch = (ack_sync == sync_d);
    assign idxWrap  = (32'(cur_idx) == NREQ - 1) ? '0 : cur_idx + IDXW'(1);

    // First set request at or after ptr; descending scan leaves the nearest hit.
    always_comb begin
        pickIdx = ptr;
        offset  = '0;
        for (int i = int'(NREQ) - 1; i >= 0; i--) begin
            offset = 32'(ptr) + 32'(i);
            if (offset >= NREQ) begin
                offset = offset - NREQ;
            end
            if (req[IDXW'(offset)]) begin
                pickIdx = IDXW'(offset);
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNext  = state;
        ptrNext    = ptr;
        gapCntNext = gapCnt;
        curIdxNext = cur_idx;
        syncDNext  = sync_d;
        syncEnNext = 1'b0;
        doneNext   = '0;
        errNext    = 1'b0;
`ifdef SYNC_ARB_TIMEOUT_EN
        toCntNext  = toCnt;
`endif
        case (state)
            IDLE: begin
                if (|req) begin
                    curIdxNext = pickIdx;
                    stateNext  = SEND;
                end
            end
            SEND: begin
                syncDNext  = ~sync_d;
                syncEnNext = 1'b1;
                stateNext  = WAIT;
`ifdef SYNC_ARB_TIMEOUT_EN
                toCntNext  = '0;
`endif
            end
            WAIT: begin
                if (ackMatch) begin
                    doneNext   = NREQ'(1) << cur_idx;
                    ptrNext    = idxWrap;
                    gapCntNext = '0;
                    stateNext  = AFTER_ACK;
                end
`ifdef SYNC_ARB_TIMEOUT_EN
                else if (toCnt == 16'(TIMEOUT)) begin
                    doneNext  = NREQ'(1) << cur_idx;
                    errNext   = 1'b1;
                    ptrNext   = idxWrap;
                    stateNext = DRAIN;
                end else begin
                    toCntNext = toCnt + 16'd1;
                end
`endif
            end
            GAP: begin
                if (gapCnt == GAPW'(MIN_GAP - 1)) begin
                    stateNext = IDLE;
                end else begin
                    gapCntNext = gapCnt + GAPW'(1);
                end
            end
`ifdef SYNC_ARB_TIMEOUT_EN
            // Late echo must land before the next toggle or the crossing desyncs.
            DRAIN: begin
                if (ackMatch) begin
                    gapCntNext = '0;
                    stateNext  = AFTER_ACK;
                end
            end
`endif
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext != IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            ptr     <= '0;
            gapCnt  <= '0;
            cur_idx <= '0;
            sync_d  <= INIT;
            sync_en <= 1'b0;
            done    <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
`ifdef SYNC_ARB_TIMEOUT_EN
            toCnt   <= '0;
`endif
        end else begin
            state   <= stateNext;
            ptr     <= ptrNext;
            gapCnt  <= gapCntNext;
            cur_idx <= curIdxNext;
            sync_d  <= syncDNext;
            sync_en <= syncEnNext;
            done    <= doneNext;
            err     <= errNext;
            busy    <= busyNext;
`ifdef SYNC_ARB_TIMEOUT_EN
            toCnt   <= toCntNext;
`endif
        end
    end

endmodule

// File: tb/tb_sync_bit_arbiter.sv
// tb_sync_bit_arbiter: directed plus randomized checks of sync_bit_arbiter against a transaction-level model.
// The far side is modelled as a delayed echo of sync_d onto ack_sync.
module tb_sync_bit_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam logic        INIT    = 1'b0;
    localparam int unsigned MIN_GAP = 2;
    localparam int unsigned TIMEOUT = 20;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [NREQ-1:0] req = '0;
    logic            sync_en, sync_d, ack_sync, err, busy;
    logic [NREQ-1:0] done;
    logic [1:0]      cur_idx;

    int   nChecks = 0;
    int   nFails  = 0;
    int   modelPtr = 0;
    logic modelTog = INIT;
    int   echoDly = 5;
    bit   echoEn  = 1'b1;
    logic [31:0] hist = '0;

    sync_bit_arbiter #(.NREQ(NREQ), .INIT(INIT), .MIN_GAP(MIN_GAP), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST), .req(req), .sync_en(sync_en), .sync_d(sync_d),
        .ack_sync(ack_sync), .done(done), .err(err), .busy(busy), .cur_idx(cur_idx)
    );

    initial forever #5 CLK = ~CLK;

    // Far side: ack_sync during cycle t equals sync_d of cycle t-echoDly; reset with RST.
    initial begin
        ack_sync = INIT;
        forever begin
            @(posedge CLK);
            #2;
            if (RST) begin
                hist     = {32{INIT}};
                ack_sync = INIT;
            end else begin
                hist = {hist[30:0], sync_d};
                if (echoEn) ack_sync = hist[echoDly];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester at or after the pointer, wrapping.
    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < int'(NREQ); k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic waitEn(output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (!sync_en && k < 40);
    endtask

    task automatic waitDone(output int k);
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (done == '0 && k < 60);
    endtask

    // One event started from a settled idle arbiter.
    task automatic doEvent(input logic [NREQ-1:0] r, input int dly, input bit dropReq);
        int expIdx, k, early;
        repeat (4) @(negedge CLK);
        expIdx   = pick(r, modelPtr);
        modelTog = ~modelTog;
        echoDly  = dly;
        req      = r;
        waitEn(k);
        chk("en_latency", k, 2);
        chk("cur_idx", 32'(cur_idx), expIdx);
        chk("sync_d", 32'(sync_d), 32'(modelTog));
        chk("busy_send", 32'(busy), 1);
        if (dropReq) req = '0;
        early = 0;
        repeat (dly) begin
            @(negedge CLK);
            if (done != '0 || sync_en) early++;
        end
        chk("early_done_or_en", early, 0);
        @(negedge CLK);
        chk("done", 32'(done), 32'(1) << expIdx);
        chk("err", 32'(err), 0);
        req      = '0;
        modelPtr = (expIdx + 1) % NREQ;
        @(negedge CLK);
        chk("done_one_cycle", 32'(done), 0);
        chk("busy_gap", 32'(busy), 1);
        @(negedge CLK);
        chk("busy_idle", 32'(busy), 0);
    endtask

    initial begin
        int k, expIdx, nDone, nEn, cyc;
        int enCyc[5];
        int doneSeen[5];
        int idxSeen[5];
        logic sdSeen[5];

        // Reset state
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        chk("rst_sync_d", 32'(sync_d), 32'(INIT));
        chk("rst_sync_en", 32'(sync_en), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cur_idx", 32'(cur_idx), 0);

        // Single requester, echo delay 5
        doEvent(4'b0001, 5, 1'b0);

        // Serve 3, then 1001: wrap gives 0 before 3
        doEvent(4'b1000, 4, 1'b0);
        doEvent(4'b1001, 6, 1'b0);
        chk("wrap_first_zero", modelPtr, 1);
        doEvent(4'b1001, 3, 1'b0);
        chk("wrap_then_three", modelPtr, 0);

        // All four held: back-to-back round robin
        repeat (4) @(negedge CLK);
        echoDly = 5;
        req = 4'b1111;
        nDone = 0; nEn = 0; cyc = 0;
        for (int i = 0; i < 5; i++) begin
            enCyc[i] = 0; doneSeen[i] = 0; idxSeen[i] = 0; sdSeen[i] = 1'bx;
        end
        while (nDone < 5 && cyc < 300) begin
            @(negedge CLK);
            cyc++;
            if (sync_en && nEn < 5) begin
                enCyc[nEn] = cyc; sdSeen[nEn] = sync_d; idxSeen[nEn] = 32'(cur_idx); nEn++;
            end
            if (done != '0) begin
                doneSeen[nDone] = 32'(done); nDone++;
            end
        end
        req = '0;
        chk("b2b_count", nDone, 5);
        chk("b2b_first_latency", enCyc[0], 2);
        for (int i = 0; i < 5; i++) begin
            expIdx   = pick(4'b1111, modelPtr);
            modelTog = ~modelTog;
            chk("b2b_done", doneSeen[i], 32'(1) << expIdx);
            chk("b2b_cur_idx", idxSeen[i], expIdx);
            chk("b2b_sync_d", 32'(sdSeen[i]), 32'(modelTog));
            if (i > 0) chk("b2b_spacing", enCyc[i] - enCyc[i-1], 5 + 3 + int'(MIN_GAP));
            modelPtr = (expIdx + 1) % NREQ;
        end
        repeat (6) @(negedge CLK);
        chk("b2b_idle", 32'(busy), 0);

        // Reset in the middle of WAIT abandons the event
        repeat (4) @(negedge CLK);
        req = 4'b0010;
        waitEn(k);
        chk("rstw_en", k, 2);
        repeat (2) @(negedge CLK);
        RST = 1'b1;
        req = '0;
        @(negedge CLK);
        RST = 1'b0;
        modelPtr = 0;
        modelTog = INIT;
        chk("rstw_sync_d", 32'(sync_d), 32'(INIT));
        chk("rstw_busy", 32'(busy), 0);
        chk("rstw_cur_idx", 32'(cur_idx), 0);
        k = 0;
        repeat (12) begin
            @(negedge CLK);
            if (done != '0 || busy) k++;
        end
        chk("rstw_no_done", k, 0);
        doEvent(4'b0100, 5, 1'b0);

        // Randomized traffic, including requests dropped before completion
        for (int n = 0; n < 20; n++) begin
            doEvent(4'($urandom_range(1, 15)), int'($urandom_range(3, 8)), $urandom_range(0, 3) == 0);
        end

`ifdef SYNC_ARB_TIMEOUT_EN
        // Timeout with no echo, then DRAIN until the late echo lands
        repeat (12) @(negedge CLK);
        echoEn   = 1'b0;
        expIdx   = pick(4'b0001, modelPtr);
        modelTog = ~modelTog;
        req      = 4'b0001;
        waitEn(k);
        chk("to_en", k, 2);
        waitDone(k);
        chk("to_done_cycle", k, int'(TIMEOUT) + 1);
        chk("to_done", 32'(done), 32'(1) << expIdx);
        chk("to_err", 32'(err), 1);
        req      = '0;
        modelPtr = (expIdx + 1) % NREQ;
        repeat (5) @(negedge CLK);
        chk("to_drain_busy", 32'(busy), 1);
        echoDly = 3;
        echoEn  = 1'b1;
        repeat (3) @(negedge CLK);
        chk("to_gap_busy", 32'(busy), 1);
        @(negedge CLK);
        chk("to_idle", 32'(busy), 0);

        // Ack and timeout in the same cycle: ack wins
        repeat (4) @(negedge CLK);
        echoDly = int'(TIMEOUT);
        repeat (2) @(negedge CLK);
        expIdx   = pick(4'b0001, modelPtr);
        modelTog = ~modelTog;
        req      = 4'b0001;
        waitEn(k);
        waitDone(k);
        chk("tie_done_cycle", k, int'(TIMEOUT) + 1);
        chk("tie_done", 32'(done), 32'(1) << expIdx);
        chk("tie_err", 32'(err), 0);
        req      = '0;
        modelPtr = (expIdx + 1) % NREQ;
        repeat (2) @(negedge CLK);
        chk("tie_idle", 32'(busy), 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
